// File: rtl/smaesh_key_sequencer.sv
// Sequences the masked key holder: loads shared key words, optionally launches the
// last-round-key core run, and gates AES block starts until key, holder and core are ready.
module smaesh_key_sequencer #(
    parameter int d = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_key_size,
    input  logic        cfg_inverse,
    input  logic [31:0] key_in_data,
    input  logic        key_in_valid,
    output logic        key_in_ready,
    input  logic        blk_start_valid,
    output logic        blk_start_ready,
    output logic [31:0] hold_data_in,
    output logic        hold_data_in_valid,
    input  logic        hold_data_in_ready,
    output logic        hold_start_fetch,
    output logic [1:0]  hold_key_size,
    output logic        hold_mode_inverse,
    input  logic        hold_busy,
    input  logic        hold_lkc_required,
    input  logic        aes_busy,
    output logic        aes_start,
    output logic        key_valid,
    output logic        cfg_error
);

    localparam int CW = $clog2(8 * d + 1);
    localparam logic [1:0] KSIZE_128 = 2'b00;
    localparam logic [1:0] KSIZE_192 = 2'b01;
    localparam logic [1:0] KSIZE_256 = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_PULSE,
        STREAM,
        WAIT_HOLDER,
        WAIT_LKC,
        AES_RUN
    } state_t;

    state_t          state_reg;
    logic [1:0]      size_reg;
    logic            inverse_reg;
    logic [CW-1:0]   count_reg;
    logic            seen_busy_reg;
    logic            key_valid_reg;
    logic            cfg_error_reg;

    logic [CW-1:0]   last_index;
    logic            in_idle;
    logic            in_stream;
    logic            cfg_fire;
    logic            blk_fire;
    logic            word_fire;
    logic            cfg_size_legal;

    // Index of the final shared word for the latched key size.
    always_comb begin
        last_index = CW'(8 * d - 1);
        case (size_reg)
            KSIZE_128: last_index = CW'(4 * d - 1);
            KSIZE_192: last_index = CW'(6 * d - 1);
            KSIZE_256: last_index = CW'(8 * d - 1);
            default:   last_index = CW'(8 * d - 1);
        endcase
    end

    assign cfg_size_legal = (cfg_key_size == KSIZE_128) || (cfg_key_size == KSIZE_192) ||
                            (cfg_key_size == KSIZE_256);

    assign in_idle   = (state_reg == IDLE);
    assign in_stream = (state_reg == STREAM);

    assign cfg_ready       = in_idle & ~hold_busy & ~aes_busy;
    // A pending configuration command takes priority over block requests.
    assign blk_start_ready = in_idle & key_valid_reg & ~hold_busy & ~aes_busy & ~cfg_valid;
    assign cfg_fire        = cfg_valid & cfg_ready;
    assign blk_fire        = blk_start_valid & blk_start_ready;
    assign word_fire       = in_stream & key_in_valid & hold_data_in_ready;

    assign hold_data_in       = key_in_data;
    assign hold_data_in_valid = in_stream & key_in_valid;
    assign key_in_ready       = in_stream & hold_data_in_ready;
    assign hold_start_fetch   = (state_reg == FETCH_PULSE);
    assign hold_key_size      = size_reg;
    assign hold_mode_inverse  = inverse_reg;
    assign aes_start          = blk_fire | ((state_reg == WAIT_HOLDER) & hold_lkc_required);
    assign key_valid          = key_valid_reg;
    assign cfg_error          = cfg_error_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            size_reg      <= 2'b00;
            inverse_reg   <= 1'b0;
            count_reg     <= '0;
            seen_busy_reg <= 1'b0;
            key_valid_reg <= 1'b0;
            cfg_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_fire) begin
                        size_reg    <= cfg_key_size;
                        inverse_reg <= cfg_inverse;
                        if (!cfg_size_legal) begin
                            cfg_error_reg <= 1'b1;
                        end else begin
                            cfg_error_reg <= 1'b0;
                            key_valid_reg <= 1'b0;
                            count_reg     <= '0;
                            state_reg     <= FETCH_PULSE;
                        end
                    end else if (blk_fire) begin
                        state_reg <= AES_RUN;
                    end
                end
                FETCH_PULSE: state_reg <= STREAM;
                STREAM: begin
                    if (word_fire) begin
                        count_reg <= count_reg + CW'(1);
                        if (count_reg == last_index) state_reg <= WAIT_HOLDER;
                    end
                end
                WAIT_HOLDER: begin
                    if (hold_lkc_required) begin
                        state_reg <= WAIT_LKC;
                    end else if (!hold_busy) begin
                        key_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                WAIT_LKC: begin
                    if (!hold_busy) begin
                        key_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                AES_RUN: begin
                    if (aes_busy) seen_busy_reg <= 1'b1;
                    // Block ends once the core has run and the holder refresh is done.
                    if (seen_busy_reg && !aes_busy && !hold_busy) begin
                        seen_busy_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
